sim_ctrl: RTL and testbench

Simulation/FPGA test-harness controller for the rv32 core. It sequences the core reset and counts run cycles. It watches the data-memory write bus for a store to the TOHOST address and reports pass, fail or timeout. It replaces the fixed "reset one cycle, run N cycles, finish" harness with a parametrised, self-checking controller that the bench or an FPGA status LED/UART can read.

---
 rtl/sim_ctrl.sv | 114 +++++++++++
 tb/tb_sim_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sim_ctrl.sv
// Test-harness controller: sequences the core reset, counts run cycles and
// watches the data-memory write bus for a tohost store (pass/fail/timeout).
module sim_ctrl #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    CNT_WIDTH    = 32,
  parameter int                    RESET_CYCLES = 4,
  parameter int                    MAX_CYCLES   = 1000,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR  = 32'h0000_1000,
  parameter int                    HOLD_ON_DONE = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  restart,
  input  logic                  mem_we,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  core_resetn,
  output logic                  running,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic                  timeout,
  output logic [DATA_WIDTH-2:0] exit_code,
  output logic [CNT_WIDTH-1:0]  cycles
);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [7:0]           RST_LAST   = 8'(RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CYC_LAST   = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CYC_MAX    = CNT_WIDTH'(MAX_CYCLES);
  localparam logic                 TIMEOUT_EN = (MAX_CYCLES != 0);
  localparam logic                 DONE_CORE  = (HOLD_ON_DONE == 0);

  state_t     state_reg;
  logic [7:0] rst_cnt_reg;
  logic       hit;
  logic       expire;

  // Only odd tohost values terminate; even values are ordinary stores.
  assign hit    = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
  assign expire = TIMEOUT_EN && (cycles == CYC_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= ST_RESET;
      rst_cnt_reg <= '0;
      core_resetn <= 1'b0;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      exit_code   <= '0;
      cycles      <= '0;
    end else begin
      case (state_reg)
        ST_RESET: begin
          if (rst_cnt_reg == RST_LAST) begin
            state_reg   <= ST_RUN;
            rst_cnt_reg <= '0;
            core_resetn <= 1'b1;
            running     <= 1'b1;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + 8'd1;
          end
        end

        ST_RUN: begin
          if (hit) begin
            state_reg   <= ST_DONE;
            running     <= 1'b0;
            done        <= 1'b1;
            exit_code   <= mem_wdata[DATA_WIDTH-1:1];
            core_resetn <= DONE_CORE;
            if (mem_wdata == DATA_WIDTH'(1)) pass <= 1'b1;
            else                             fail <= 1'b1;
          end else if (expire) begin
            state_reg   <= ST_DONE;
            running     <= 1'b0;
            done        <= 1'b1;
            timeout     <= 1'b1;
            cycles      <= CYC_MAX;
            core_resetn <= DONE_CORE;
          end else if (cycles != '1) begin
            cycles <= cycles + CNT_WIDTH'(1);
          end
        end

        ST_DONE: begin
          if (restart) begin
            state_reg   <= ST_RESET;
            rst_cnt_reg <= '0;
            core_resetn <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            exit_code   <= '0;
            cycles      <= '0;
          end
        end

        default: state_reg <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_sim_ctrl.sv
// Directed bench for sim_ctrl: table of tohost runs on a MAX_CYCLES=50 instance
// plus hand sequences for reset, restart, async reset and a long no-timeout run.
module tb_sim_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        restart0 = 1'b0, restart1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;

  logic        core_resetn0, running0, done0, pass0, fail0, timeout0;
  logic [30:0] exit_code0;
  logic [31:0] cycles0;
  logic        core_resetn1, running1, done1, pass1, fail1, timeout1;
  logic [30:0] exit_code1;
  logic [31:0] cycles1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sim_ctrl #(.MAX_CYCLES(50), .HOLD_ON_DONE(1)) dut0 (
    .clk(clk), .resetn(resetn), .restart(restart0),
    .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .core_resetn(core_resetn0), .running(running0), .done(done0),
    .pass(pass0), .fail(fail0), .timeout(timeout0),
    .exit_code(exit_code0), .cycles(cycles0)
  );

  sim_ctrl #(.MAX_CYCLES(0), .HOLD_ON_DONE(0)) dut1 (
    .clk(clk), .resetn(resetn), .restart(restart1),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .core_resetn(core_resetn1), .running(running1), .done(done1),
    .pass(pass1), .fail(fail1), .timeout(timeout1),
    .exit_code(exit_code1), .cycles(cycles1)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          wcyc;
    logic        exp_pass;
    logic        exp_fail;
    logic        exp_to;
    logic [30:0] exp_code;
    logic [31:0] exp_cycles;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart0();
    restart0 = 1'b1;
    step();
    restart0 = 1'b0;
  endtask

  task automatic write0(input logic [31:0] a, input logic [31:0] d);
    we0 = 1'b1; addr0 = a; wdata0 = d;
    step();
    we0 = 1'b0; addr0 = '0; wdata0 = '0;
  endtask

  task automatic check_final0(input string tag, input logic p, input logic f, input logic t,
                              input logic [30:0] code, input logic [31:0] cyc);
    chk({tag, ".done"}, done0, 1'b1);
    chk({tag, ".pass"}, pass0, p);
    chk({tag, ".fail"}, fail0, f);
    chk({tag, ".timeout"}, timeout0, t);
    chk({tag, ".exit_code"}, exit_code0, code);
    chk({tag, ".cycles"}, cycles0, cyc);
    chk({tag, ".running"}, running0, 1'b0);
    chk({tag, ".core_resetn"}, core_resetn0, 1'b0);
  endtask

  initial begin
    //               addr           data          wcyc pass fail to  code           cycles
    vecs[0] = '{32'h0000_1000, 32'h0000_0002, 10, 1'b0, 1'b0, 1'b1, 31'd0,          32'd50};
    vecs[1] = '{32'h0000_1004, 32'h0000_0007, 10, 1'b0, 1'b0, 1'b1, 31'd0,          32'd50};
    vecs[2] = '{32'h1000_1000, 32'h0000_0001, 10, 1'b0, 1'b0, 1'b1, 31'd0,          32'd50};
    vecs[3] = '{32'h0000_1000, 32'h0000_0007, 15, 1'b0, 1'b1, 1'b0, 31'd3,          32'd15};
    vecs[4] = '{32'h0000_1000, 32'h0000_0001, 49, 1'b1, 1'b0, 1'b0, 31'd0,          32'd49};
    vecs[5] = '{32'h0000_1000, 32'h0000_0003, 48, 1'b0, 1'b1, 1'b0, 31'd1,          32'd48};
    vecs[6] = '{32'h0000_1000, 32'hFFFF_FFFF,  5, 1'b0, 1'b1, 1'b0, 31'h7FFF_FFFF, 32'd5};
    vecs[7] = '{32'h0000_1000, 32'h0000_0005, 30, 1'b0, 1'b1, 1'b0, 31'd2,          32'd30};
    vecs[8] = '{32'h0000_1000, 32'h0000_0001, 20, 1'b1, 1'b0, 1'b0, 31'd0,          32'd20};

    // Reset state and reset sequencing
    #1 resetn = 1'b0;
    #2;
    chk("rst.core_resetn", core_resetn0, 1'b0);
    chk("rst.done", done0, 1'b0);
    chk("rst.running", running0, 1'b0);
    chk("rst.cycles", cycles0, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rstseq.edge%0d.core_resetn", k), core_resetn0, (k == 4));
    end
    chk("rstseq.running", running0, 1'b1);
    chk("rstseq.cycles", cycles0, 32'd0);
    $display("reset sequence: core_resetn=%0b running=%0b cycles=%0d", core_resetn0, running0, cycles0);

    // Ignored writes followed by a failing tohost write in one run
    repeat (5) step();
    write0(32'h0000_1000, 32'h0000_0002);
    chk("ign.even.done", done0, 1'b0);
    write0(32'h0000_1004, 32'h0000_0007);
    chk("ign.addr.done", done0, 1'b0);
    chk("ign.cycles", cycles0, 32'd7);
    step();
    write0(32'h0000_1000, 32'h0000_0007);
    check_final0("failseq", 1'b0, 1'b1, 1'b0, 31'd3, 32'd8);
    $display("fail sequence: fail=%0b exit_code=%0d cycles=%0d", fail0, exit_code0, cycles0);

    // Table of complete runs
    for (int i = 0; i < 9; i++) begin
      pulse_restart0();
      for (int k = 0; k < 20 && !running0; k++) step();
      chk($sformatf("vec%0d.started", i), running0, 1'b1);
      repeat (vecs[i].wcyc) step();
      write0(vecs[i].addr, vecs[i].data);
      for (int k = 0; k < 80 && !done0; k++) step();
      check_final0($sformatf("vec%0d", i), vecs[i].exp_pass, vecs[i].exp_fail, vecs[i].exp_to,
                   vecs[i].exp_code, vecs[i].exp_cycles);
      $display("vec %0d: addr=%h data=%h at %0d -> pass=%0b fail=%0b timeout=%0b code=%0h cycles=%0d",
               i, vecs[i].addr, vecs[i].data, vecs[i].wcyc, pass0, fail0, timeout0, exit_code0, cycles0);
    end

    // Restart after pass; restart ignored while running
    step();
    chk("hold.core_resetn", core_resetn0, 1'b0);
    chk("hold.pass", pass0, 1'b1);
    pulse_restart0();
    chk("rs.done", done0, 1'b0);
    chk("rs.pass", pass0, 1'b0);
    chk("rs.cycles", cycles0, 32'd0);
    chk("rs.exit_code", exit_code0, 31'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("rs.edge%0d.core_resetn", k), core_resetn0, (k == 4));
    end
    repeat (3) step();
    pulse_restart0();
    chk("rs.run_restart.running", running0, 1'b1);
    chk("rs.run_restart.cycles", cycles0, 32'd4);
    repeat (8) step();
    write0(32'h0000_1000, 32'h0000_0005);
    check_final0("rs.run2", 1'b0, 1'b1, 1'b0, 31'd2, 32'd12);
    $display("restart run: fail=%0b exit_code=%0d cycles=%0d", fail0, exit_code0, cycles0);

    // Asynchronous reset between edges
    pulse_restart0();
    for (int k = 0; k < 20 && !running0; k++) step();
    repeat (10) step();
    chk("async.pre.cycles", cycles0, 32'd10);
    #2 resetn = 1'b0;
    #1;
    chk("async.core_resetn0", core_resetn0, 1'b0);
    chk("async.cycles0", cycles0, 32'd0);
    chk("async.running0", running0, 1'b0);
    chk("async.core_resetn1", core_resetn1, 1'b0);
    chk("async.cycles1", cycles1, 32'd0);
    $display("async reset: core_resetn=%0b cycles=%0d", core_resetn0, cycles0);

    // Long run with timeout disabled, then a pass that leaves the core running
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (4) step();
    chk("long.start.core_resetn", core_resetn1, 1'b1);
    repeat (5000) step();
    chk("long.cycles", cycles1, 32'd5000);
    chk("long.timeout", timeout1, 1'b0);
    chk("long.done", done1, 1'b0);
    we1 = 1'b1; addr1 = 32'h0000_1000; wdata1 = 32'h0000_0001;
    step();
    we1 = 1'b0; addr1 = '0; wdata1 = '0;
    chk("long.pass", pass1, 1'b1);
    chk("long.done2", done1, 1'b1);
    chk("long.cycles2", cycles1, 32'd5000);
    chk("long.core_resetn", core_resetn1, 1'b1);
    chk("long.running", running1, 1'b0);
    $display("long run: cycles=%0d pass=%0b core_resetn=%0b", cycles1, pass1, core_resetn1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
